// File: rtl/glint_blob_tracker_if.sv
// glint_blob_tracker_if: pixel stream, tuning inputs and per-blob results.
// master = stream source / result consumer, slave = tracker.
interface glint_blob_tracker_if #(
  parameter int NSLOT = 10,
  parameter int W     = 12
);
  logic                   per_frame_vsync;
  logic                   per_frame_href;
  logic                   per_frame_clken;
  logic [7:0]             per_img_Y;
  logic [7:0]             th_min;
  logic [7:0]             th_max;
  logic [W-1:0]           gap_max;
  logic [W-1:0]           row_gap;
  logic [W-1:0]           w_min;
  logic [W-1:0]           w_max;
  logic [W-1:0]           h_min;
  logic [W-1:0]           h_max;
  logic [NSLOT-1:0]       obj_valid;
  logic [NSLOT*4*W-1:0]   obj_bbox;
  logic [NSLOT*2*W-1:0]   obj_center;
  logic                   overflow;
  logic                   frame_done;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
    output th_min, th_max, gap_max, row_gap, w_min, w_max, h_min, h_max,
    input  obj_valid, obj_bbox, obj_center, overflow, frame_done
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
    input  th_min, th_max, gap_max, row_gap, w_min, w_max, h_min, h_max,
    output obj_valid, obj_bbox, obj_center, overflow, frame_done
  );
endinterface

// File: rtl/glint_blob_tracker.sv
// glint_blob_tracker: horizontal runs of in-window pixels, joined across rows
// into NSLOT blobs; bbox/centre/valid/overflow published at vsync rise (bus).
module glint_blob_tracker #(
  parameter int NSLOT     = 10,
  parameter int W         = 12,
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int EDGE      = 10
) (
  input logic clk,
  input logic rst_n,
  glint_blob_tracker_if.slave bus
);
  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [W-1:0] XLAST = W'(IMG_HDISP - 1);
  localparam logic [W-1:0] YTOP  = W'(EDGE);
  localparam logic [W-1:0] YBOT  = W'(IMG_VDISP - 1 - EDGE);

  typedef enum logic {IDLE, OPEN} run_e;

  logic         vs_q, vs_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  run_e         st_q, st_d;
  logic [W-1:0] rl_q, rl_d, rr_q, rr_d, gap_q, gap_d;
  logic         cv_q, cv_d;
  logic [W-1:0] cl_q, cl_d, cr_q, cr_d, cy_q, cy_d;

  logic [NSLOT-1:0] act_q, act_d;
  logic [W-1:0] top_q [NSLOT], top_d [NSLOT];
  logic [W-1:0] dn_q  [NSLOT], dn_d  [NSLOT];
  logic [W-1:0] lf_q  [NSLOT], lf_d  [NSLOT];
  logic [W-1:0] rt_q  [NSLOT], rt_d  [NSLOT];
  logic [W-1:0] ll_q  [NSLOT], ll_d  [NSLOT];
  logic [W-1:0] lr_q  [NSLOT], lr_d  [NSLOT];
  logic [W-1:0] ly_q  [NSLOT], ly_d  [NSLOT];
  logic         pend_q, pend_d;

  logic [NSLOT-1:0]     vld_q, vld_d;
  logic [NSLOT*4*W-1:0] bb_q, bb_d;
  logic [NSLOT*2*W-1:0] ct_q, ct_d;
  logic                 ovf_q, ovf_d, done_q, done_d;

  logic         fs, pix, hit, row_ok, last_x, close;
  logic [W-1:0] c_l, c_r, gap_n, wid;
  logic         m_hit, f_hit;
  logic [IW-1:0] m_idx, f_idx;
  logic [W-1:0] hgt;
  logic [W:0]   sx, sy;
  logic         ok;
  logic         unused_href;

  assign unused_href = bus.per_frame_href;

  assign vs_d   = bus.per_frame_vsync;
  assign fs     = bus.per_frame_vsync & ~vs_q;
  assign pix    = bus.per_frame_clken & ~fs;
  assign hit    = (bus.per_img_Y >= bus.th_min) &&
                  (bus.per_img_Y <= bus.th_max);
  assign row_ok = (y_q >= YTOP) && (y_q <= YBOT);
  assign last_x = (x_q == XLAST);
  assign gap_n  = gap_q + W'(1);
  assign done_d = fs;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (fs) begin
      x_d = '0;
      y_d = '0;
    end else if (bus.per_frame_clken) begin
      if (last_x) begin
        x_d = '0;
        y_d = y_q + W'(1);
      end else begin
        x_d = x_q + W'(1);
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    rl_d  = rl_q;
    rr_d  = rr_q;
    gap_d = gap_q;
    close = 1'b0;
    c_l   = rl_q;
    c_r   = rr_q;
    if (fs) begin
      st_d = IDLE;
    end else if (pix) begin
      unique case (st_q)
        IDLE: begin
          if (hit && row_ok) begin
            rl_d  = x_q;
            rr_d  = x_q;
            gap_d = '0;
            c_l   = x_q;
            c_r   = x_q;
            // a lone hit on the last column is a complete run
            if (last_x) close = 1'b1;
            else        st_d  = OPEN;
          end
        end
        OPEN: begin
          if (hit) begin
            rr_d  = x_q;
            gap_d = '0;
            c_r   = x_q;
          end else begin
            gap_d = gap_n;
          end
          if (last_x || (!hit && gap_n >= bus.gap_max)) begin
            close = 1'b1;
            st_d  = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  assign wid  = c_r - c_l + W'(1);
  assign cv_d = close && (wid >= bus.w_min) && (wid <= bus.w_max);
  assign cl_d = c_l;
  assign cr_d = c_r;
  assign cy_d = y_q;

  // descending scan leaves the lowest matching / free index
  always_comb begin
    m_hit = 1'b0;
    f_hit = 1'b0;
    m_idx = '0;
    f_idx = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (act_q[k] && (cl_q <= lr_q[k]) && (cr_q >= ll_q[k]) &&
          ((cy_q - ly_q[k]) <= bus.row_gap)) begin
        m_hit = 1'b1;
        m_idx = IW'(k);
      end
      if (!act_q[k]) begin
        f_hit = 1'b1;
        f_idx = IW'(k);
      end
    end
  end

  always_comb begin
    act_d  = act_q;
    top_d  = top_q;
    dn_d   = dn_q;
    lf_d   = lf_q;
    rt_d   = rt_q;
    ll_d   = ll_q;
    lr_d   = lr_q;
    ly_d   = ly_q;
    pend_d = pend_q;
    if (fs) begin
      act_d  = '0;
      pend_d = 1'b0;
    end else if (cv_q) begin
      if (m_hit) begin
        if (cl_q < lf_q[m_idx]) lf_d[m_idx] = cl_q;
        if (cr_q > rt_q[m_idx]) rt_d[m_idx] = cr_q;
        dn_d[m_idx] = cy_q;
        ll_d[m_idx] = cl_q;
        lr_d[m_idx] = cr_q;
        ly_d[m_idx] = cy_q;
      end else if (f_hit) begin
        act_d[f_idx] = 1'b1;
        top_d[f_idx] = cy_q;
        dn_d[f_idx]  = cy_q;
        lf_d[f_idx]  = cl_q;
        rt_d[f_idx]  = cr_q;
        ll_d[f_idx]  = cl_q;
        lr_d[f_idx]  = cr_q;
        ly_d[f_idx]  = cy_q;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    bb_d  = bb_q;
    ct_d  = ct_q;
    ovf_d = ovf_q;
    hgt   = '0;
    sx    = '0;
    sy    = '0;
    ok    = 1'b0;
    if (fs) begin
      ovf_d = pend_q;
      for (int k = 0; k < NSLOT; k++) begin
        hgt = dn_q[k] - top_q[k] + W'(1);
        ok  = act_q[k] && (hgt >= bus.h_min) && (hgt <= bus.h_max);
        sx  = {1'b0, lf_q[k]} + {1'b0, rt_q[k]};
        sy  = {1'b0, top_q[k]} + {1'b0, dn_q[k]};
        vld_d[k] = ok;
        bb_d[k*4*W +: 4*W] = ok ? {top_q[k], dn_q[k], lf_q[k], rt_q[k]}
                                : '0;
        ct_d[k*2*W +: 2*W] = ok ? {sx[W:1], sy[W:1]} : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      st_q   <= IDLE;
      rl_q   <= '0;
      rr_q   <= '0;
      gap_q  <= '0;
      cv_q   <= 1'b0;
      cl_q   <= '0;
      cr_q   <= '0;
      cy_q   <= '0;
      act_q  <= '0;
      pend_q <= 1'b0;
      vld_q  <= '0;
      bb_q   <= '0;
      ct_q   <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
        top_q[k] <= '0;
        dn_q[k]  <= '0;
        lf_q[k]  <= '0;
        rt_q[k]  <= '0;
        ll_q[k]  <= '0;
        lr_q[k]  <= '0;
        ly_q[k]  <= '0;
      end
    end else begin
      vs_q   <= vs_d;
      x_q    <= x_d;
      y_q    <= y_d;
      st_q   <= st_d;
      rl_q   <= rl_d;
      rr_q   <= rr_d;
      gap_q  <= gap_d;
      cv_q   <= cv_d;
      cl_q   <= cl_d;
      cr_q   <= cr_d;
      cy_q   <= cy_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      bb_q   <= bb_d;
      ct_q   <= ct_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      top_q  <= top_d;
      dn_q   <= dn_d;
      lf_q   <= lf_d;
      rt_q   <= rt_d;
      ll_q   <= ll_d;
      lr_q   <= lr_d;
      ly_q   <= ly_d;
    end
  end

  assign bus.obj_valid  = vld_q;
  assign bus.obj_bbox   = bb_q;
  assign bus.obj_center = ct_q;
  assign bus.overflow   = ovf_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_glint_blob_tracker.sv
// tb_glint_blob_tracker: random and directed frames on a small image,
// row-scan reference model, expected commits queued for a frame_done monitor.
module tb_glint_blob_tracker;
  localparam int NSLOT = 4;
  localparam int W     = 12;
  localparam int H     = 64;
  localparam int V     = 32;
  localparam int EDGE  = 3;
  localparam int BW    = NSLOT * 4 * W;

  typedef struct {
    logic [NSLOT-1:0]     v;
    logic [NSLOT*4*W-1:0] b;
    logic [NSLOT*2*W-1:0] c;
    logic                 o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  glint_blob_tracker_if #(.NSLOT(NSLOT), .W(W)) bus ();

  glint_blob_tracker #(
    .NSLOT(NSLOT), .W(W), .IMG_HDISP(H), .IMG_VDISP(V), .EDGE(EDGE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  exp_t q[$];
  bit   img [V][H];
  int   n_chk = 0;
  int   n_pass = 0;

  int g_thmin, g_thmax, g_gap, g_rowgap, g_wmin, g_wmax, g_hmin, g_hmax;

  int m_act [NSLOT];
  int m_top [NSLOT];
  int m_dn  [NSLOT];
  int m_lf  [NSLOT];
  int m_rt  [NSLOT];
  int m_ll  [NSLOT];
  int m_lr  [NSLOT];
  int m_ly  [NSLOT];
  int m_pend;

  task automatic chk(input string nm, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.frame_done) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL frame_done: got unexpected pulse expected none");
      end else begin
        e = q.pop_front();
        chk("obj_valid",  BW'(bus.obj_valid),  BW'(e.v));
        chk("obj_bbox",   BW'(bus.obj_bbox),   BW'(e.b));
        chk("obj_center", BW'(bus.obj_center), BW'(e.c));
        chk("overflow",   BW'(bus.overflow),   BW'(e.o));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default();
    g_thmin = 60; g_thmax = 120; g_gap = 2; g_rowgap = 1;
    g_wmin = 1; g_wmax = 20; g_hmin = 1; g_hmax = 20;
  endtask

  task automatic apply_cfg();
    bus.th_min  = 8'(g_thmin);
    bus.th_max  = 8'(g_thmax);
    bus.gap_max = W'(g_gap);
    bus.row_gap = W'(g_rowgap);
    bus.w_min   = W'(g_wmin);
    bus.w_max   = W'(g_wmax);
    bus.h_min   = W'(g_hmin);
    bus.h_max   = W'(g_hmax);
  endtask

  task automatic clear_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) img[y][x] = 1'b0;
  endtask

  task automatic rect(input int x0, y0, w, h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (y >= 0 && y < V && x >= 0 && x < H) img[y][x] = 1'b1;
  endtask

  function automatic logic [7:0] hit_val();
    case ($urandom_range(0, 3))
      0: return 8'(g_thmin);
      1: return 8'(g_thmax);
      default: return 8'($urandom_range(g_thmin, g_thmax));
    endcase
  endfunction

  function automatic logic [7:0] miss_val();
    if ($urandom_range(0, 1) == 1)
      return ($urandom_range(0, 1) == 1) ? 8'(g_thmin - 1)
                                         : 8'($urandom_range(0, g_thmin - 1));
    return ($urandom_range(0, 1) == 1) ? 8'(g_thmax + 1)
                                       : 8'($urandom_range(g_thmax + 1, 255));
  endfunction

  task automatic place(input int l, input int r, input int y);
    int wd;
    wd = r - l + 1;
    if (wd < g_wmin || wd > g_wmax) return;
    for (int k = 0; k < NSLOT; k++) begin
      if (m_act[k] != 0 && l <= m_lr[k] && r >= m_ll[k] &&
          y - m_ly[k] <= g_rowgap) begin
        if (l < m_lf[k]) m_lf[k] = l;
        if (r > m_rt[k]) m_rt[k] = r;
        m_dn[k] = y;
        m_ll[k] = l; m_lr[k] = r; m_ly[k] = y;
        return;
      end
    end
    for (int k = 0; k < NSLOT; k++) begin
      if (m_act[k] == 0) begin
        m_act[k] = 1;
        m_top[k] = y; m_dn[k] = y;
        m_lf[k] = l; m_rt[k] = r;
        m_ll[k] = l; m_lr[k] = r; m_ly[k] = y;
        return;
      end
    end
    m_pend = 1;
  endtask

  // runs = hit groups whose internal miss stretches are shorter than gap_max
  task automatic model(output exp_t e);
    int l, r, x, m, h;
    bit done;
    for (int k = 0; k < NSLOT; k++) m_act[k] = 0;
    m_pend = 0;
    for (int y = EDGE; y <= V - 1 - EDGE; y++) begin
      x = 0;
      while (x < H) begin
        if (!img[y][x]) begin
          x++;
          continue;
        end
        l = x; r = x; x++; done = 1'b0;
        while (!done && x < H) begin
          if (img[y][x]) begin
            r = x; x++;
          end else begin
            m = 0;
            while (x + m < H && !img[y][x + m]) m++;
            if (x + m < H && m < g_gap) x += m;
            else begin
              done = 1'b1;
              x += m;
            end
          end
        end
        place(l, r, y);
      end
    end
    e.v = '0; e.b = '0; e.c = '0; e.o = 1'(m_pend);
    for (int k = 0; k < NSLOT; k++) begin
      h = m_dn[k] - m_top[k] + 1;
      if (m_act[k] != 0 && h >= g_hmin && h <= g_hmax) begin
        e.v[k] = 1'b1;
        e.b[k*4*W +: 4*W] = {W'(m_top[k]), W'(m_dn[k]),
                             W'(m_lf[k]), W'(m_rt[k])};
        e.c[k*2*W +: 2*W] = {W'((m_lf[k] + m_rt[k]) / 2),
                             W'((m_top[k] + m_dn[k]) / 2)};
      end
    end
  endtask

  task automatic push_empty();
    exp_t e;
    e.v = '0; e.b = '0; e.c = '0; e.o = 1'b0;
    q.push_back(e);
  endtask

  task automatic frame_head();
    bus.per_frame_vsync = 1'b1;
    bus.per_frame_clken = 1'b0;
    tick();
    apply_cfg();
    tick();
  endtask

  task automatic drive_row(input int y);
    for (int x = 0; x < H; x++) begin
      bus.per_frame_clken = 1'b1;
      bus.per_frame_href  = 1'b1;
      bus.per_img_Y = img[y][x] ? hit_val() : miss_val();
      tick();
    end
  endtask

  task automatic run_frame();
    exp_t e;
    frame_head();
    for (int y = 0; y < V; y++) drive_row(y);
    bus.per_frame_clken = 1'b0;
    bus.per_frame_href  = 1'b0;
    tick();
    tick();
    model(e);
    q.push_back(e);
    bus.per_frame_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"},  BW'(bus.obj_valid),  '0);
    chk({tag, "_bbox"},   BW'(bus.obj_bbox),   '0);
    chk({tag, "_center"}, BW'(bus.obj_center), '0);
    chk({tag, "_ovf"},    BW'(bus.overflow),   '0);
    chk({tag, "_done"},   BW'(bus.frame_done), '0);
  endtask

  task automatic run_frame_reset();
    frame_head();
    for (int y = 0; y < V / 2; y++) drive_row(y);
    rst_n = 1'b0;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_frame_href  = 1'b0;
    #2;
    reset_checks("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_empty();
  endtask

  task automatic rand_frame();
    int n;
    g_thmin  = $urandom_range(1, 120);
    g_thmax  = $urandom_range(g_thmin, 254);
    g_gap    = $urandom_range(0, 3);
    g_rowgap = $urandom_range(0, 3);
    g_wmin   = $urandom_range(1, 3);
    g_wmax   = $urandom_range(g_wmin, 24);
    g_hmin   = $urandom_range(1, 3);
    g_hmax   = $urandom_range(g_hmin, 20);
    clear_img();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++)
      rect($urandom_range(0, H - 2), $urandom_range(0, V - 2),
           $urandom_range(1, 12), $urandom_range(1, 12));
    n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++)
      img[$urandom_range(0, V - 1)][$urandom_range(0, H - 1)] = 1'b1;
    run_frame();
  endtask

  initial begin
    int waited;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_Y       = '0;
    set_default();
    apply_cfg();
    repeat (3) tick();
    reset_checks("rst");
    rst_n = 1'b1;
    repeat (2) tick();

    push_empty();

    clear_img(); rect(20, 10, 4, 4);
    run_frame();

    clear_img();
    img[10][20] = 1'b1; img[10][21] = 1'b1; img[10][23] = 1'b1;
    run_frame();
    g_gap = 0;
    run_frame();
    set_default();

    clear_img();
    for (int i = 0; i <= NSLOT; i++) rect(2 + 10 * i, 8, 2, 2);
    run_frame();
    clear_img(); rect(30, 15, 3, 3);
    run_frame();

    clear_img(); rect(10, 5, 2, 20); rect(30, 27, 25, 1);
    g_hmax = 15;
    run_frame();
    set_default();

    clear_img();
    img[1][10] = 1'b1; img[2][20] = 1'b1;
    img[29][30] = 1'b1; img[30][40] = 1'b1;
    img[3][50] = 1'b1; img[28][5] = 1'b1;
    run_frame();

    clear_img(); rect(20, 10, 4, 4);
    run_frame_reset();
    run_frame();

    clear_img(); rect(5, 10, 4, 4); rect(60, 10, 4, 4);
    run_frame();

    clear_img(); rect(20, 10, 4, 1); rect(20, 13, 4, 1);
    g_rowgap = 2;
    run_frame();
    set_default();

    for (int i = 0; i < 10; i++) rand_frame();

    bus.per_frame_vsync = 1'b1;
    tick();
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("drain", BW'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/glint_blob_tracker.md
Name: glint_blob_tracker

Overview:
Parametrised successor to the single-configuration glint detector. It extracts horizontal runs of in-window pixels from a thresholded pixel stream and associates runs across rows into up to NSLOT tracked blobs. At each frame boundary it publishes per-blob bounding box, centre and validity. It sits between the YCbCr threshold stage and the eye-position/overlay logic.

Parameters:
NSLOT, 10, number of blob slots (1..16)
W, 12, coordinate width
IMG_HDISP, 1280, active pixels per line
IMG_VDISP, 720, active lines per frame
EDGE, 10, rows y<EDGE or y>IMG_VDISP-1-EDGE are ignored

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  frame valid
per_frame_href  in  1  line valid
per_frame_clken  in  1  pixel strobe
per_img_Y  in  8  pixel value under test
th_min / th_max  in  8 each  inclusive in-window limits
gap_max  in  W  tolerated out-of-window pixels inside a run
row_gap  in  W  max row distance for association
w_min / w_max  in  W  accepted run width, inclusive
h_min / h_max  in  W  accepted blob height, inclusive
obj_valid  out  NSLOT  blob k valid for last frame
obj_bbox  out  NSLOT*4*W  slot k = {top,down,left,right}
obj_center  out  NSLOT*2*W  slot k = {x,y}
overflow  out  1  a run found no free slot last frame
frame_done  out  1  one-cycle pulse, outputs updated

Behaviour:
- Reset: all outputs 0; all slots free; counters 0. Asserting reset mid-frame discards all state.
- Frame start = vsync rising edge (registered compare). The same cycle zeroes x/y, closes nothing, and discards any open run.
- x advances on clken and wraps to 0 at IMG_HDISP-1, incrementing y. Pixels with no clken are ignored.
- Hit = th_min<=Y<=th_max.
- Run FSM: IDLE, OPEN.
  - IDLE->OPEN on a hit in a non-edge row: left=right=x, gap=0.
  - In OPEN, a hit sets right=x and gap=0; a miss increments gap.
  - OPEN->IDLE when gap reaches gap_max (if gap_max=0, on the first miss) or at x=IMG_HDISP-1. A hit at the last x is included.
- Run accepted if w_min <= right-left+1 <= w_max; otherwise dropped. At most one run closes per cycle.
- Association, one cycle after close:
  - Match = lowest-index active slot with run.left<=slot.last_right, run.right>=slot.last_left, and y-slot.last_y<=row_gap.
  - On match: left=min, right=max, down=y; last_left/last_right/last_y take the run's values.
  - No match: allocate the lowest free slot with top=down=y, left/right from the run.
  - No free slot: run dropped and overflow_pend sticky-set.
- Commit at frame start, using slot contents from before clearing:
  - obj_valid[k] = active and h_min <= down-top+1 <= h_max.
  - Invalid slots output bbox/center 0.
  - center x=(left+right)>>1 and y=(top+down)>>1, with the sum computed at W+1 bits.
  - overflow<=overflow_pend. Slots and pend then clear.
- frame_done pulses the cycle after commit. Outputs hold until the next commit.
- A run closing in the same cycle as frame start is discarded, not associated.

Test Plan:
- Single 4x4 hit square at x=100..103, y=200..203, gap_max=2, w 1..20, h 1..20 -> after next vsync rise: obj_valid=1 (slot0), bbox {200,203,100,103}, center {101,201}, frame_done one pulse.
- Run with one miss pixel (x=100,101,_,103) and gap_max=2 -> single run, left=100, right=103. With gap_max=0 -> two runs in two slots.
- NSLOT+1 disjoint 2x2 blobs -> slots 0..NSLOT-1 valid, last blob dropped, overflow=1. Next frame with one blob -> overflow=0.
- Blob 30 rows tall with h_max=20 -> obj_valid bit 0, bbox/center 0. Run width 25 with w_max=20 -> no slot allocated.
- Hits on rows 5 and 715 (EDGE=10) -> no blobs. rst_n pulsed mid-frame -> all outputs 0, next frame tracks normally.
- Two blobs in the same rows separated by 50 px -> slots 0 and 1, left blob in slot 0. Row gap of 3 with row_gap=2 -> continuation lands in a new slot.
